// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-wide UART transmitter.
// Includes the frame-state encoding, the data width and the frame-length arithmetic.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Total clock cycles of one frame, start bit through last stop bit.
    function automatic int frame_len(input int clks_per_bit, input int parity_en, input int stop_bits);
        return (1 + UART_DATA_BITS + parity_en + stop_bits) * clks_per_bit;
    endfunction

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and emits a one-cycle
// bit_done pulse on the last count of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_done_o
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap at the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = en_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// Serial transmitter: one byte per valid/ready handshake, sent as start bit,
// 8 data bits LSB-first, optional even parity and 1 or 2 stop bits on a registered pin.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx,
    output logic                      busy
);

    generate
        if ((CLKS_PER_BIT < 2) || ((STOP_BITS != 1) && (STOP_BITS != 2)) ||
            ((PARITY_EN != 0) && (PARITY_EN != 1))) begin : g_bad_params
            $error("uart_byte_tx: illegal parameter set");
        end
    endgenerate

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      par_q, par_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      stop_cnt_q, stop_cnt_d;
    logic                      tx_q, tx_d;
    logic                      xfer_s;
    logic                      bit_done_s;

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign tx       = tx_q;
    assign xfer_s   = tx_valid && tx_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (xfer_s),
        .en_i      (busy),
        .bit_done_o(bit_done_s)
    );

    // Frame sequencing; every transition except the handshake waits for bit_done.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_d    = ST_START;
                    shift_d    = tx_data;
                    par_d      = even_parity(tx_data);
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    if ((STOP_BITS == 2) && (stop_cnt_q == 1'b0)) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so the pin changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= {UART_DATA_BITS{1'b0}};
            par_q      <= 1'b0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three parameterisations driven from directed and random stimulus,
// checked each cycle against a queue-of-line-levels model plus hand-computed frame pins.
module tb_uart_byte_tx;

    localparam int N = 3;

    int clks_a [N] = '{4, 4, 2};
    int par_a  [N] = '{0, 1, 0};
    int stp_a  [N] = '{1, 1, 2};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   tx_data [N];
    logic [N-1:0] tx_valid;
    logic [N-1:0] tx_ready;
    logic [N-1:0] tx;
    logic [N-1:0] busy;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  run_cmp     = 1'b0;
    bit  mq [N][$];

    logic [127:0] t_cap;
    logic [127:0] b_cap;
    logic [31:0]  v;

    always #5 clk = ~clk;

    uart_byte_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]));

    uart_byte_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]));

    uart_byte_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one queued line level per clock cycle of the frame.
    function automatic void push_frame(input int i, input logic [7:0] d);
        int c;
        c = clks_a[i];
        for (int k = 0; k < c; k++) mq[i].push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < c; k++) mq[i].push_back(d[b]);
        if (par_a[i] != 0)
            for (int k = 0; k < c; k++) mq[i].push_back(^d);
        for (int k = 0; k < stp_a[i] * c; k++) mq[i].push_back(1'b1);
    endfunction

    function automatic int ones(input logic [127:0] x, input int lo, input int hi);
        int c;
        c = 0;
        for (int k = lo; k <= hi; k++) if (x[k] === 1'b1) c++;
        return c;
    endfunction

    always @(negedge clk) begin
        bit exp_tx;
        bit exp_busy;
        if (run_cmp && !rst) begin
            for (int i = 0; i < N; i++) begin
                if (mq[i].size() > 0) begin
                    exp_tx   = mq[i].pop_front();
                    exp_busy = 1'b1;
                end else begin
                    exp_tx   = 1'b1;
                    exp_busy = 1'b0;
                end
                chk($sformatf("tx[%0d]", i), 32'(tx[i]), 32'(exp_tx));
                chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(exp_busy));
                chk($sformatf("tx_ready[%0d]", i), 32'(tx_ready[i]), 32'(!exp_busy));
                if (!exp_busy && tx_valid[i] === 1'b1) push_frame(i, tx_data[i]);
            end
        end
    end

    task automatic capture(input int i, input int n, output logic [127:0] txs, output logic [127:0] bsy);
        txs = '0;
        bsy = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            txs[k] = tx[i];
            bsy[k] = busy[i];
        end
    endtask

    // Returns at posedge+1 of the transfer edge, with tx_valid already dropped.
    task automatic start_tx(input int i, input logic [7:0] d);
        int w;
        w = 0;
        @(posedge clk); #1;
        while (tx_ready[i] !== 1'b1 && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_before_send", 32'(tx_ready[i]), 32'd1);
        tx_valid[i] = 1'b1;
        tx_data[i]  = d;
        @(posedge clk); #1;
        tx_valid[i] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_valid = '0;
        for (int i = 0; i < N; i++) tx_data[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("reset_tx", 32'(tx[i]), 32'd1);
            chk("reset_ready", 32'(tx_ready[i]), 32'd1);
            chk("reset_busy", 32'(busy[i]), 32'd0);
        end
        rst     = 1'b0;
        run_cmp = 1'b1;

        // 0x55, no parity, one stop bit.
        start_tx(0, 8'h55);
        capture(0, 44, t_cap, b_cap);
        v = '0;
        for (int k = 0; k < 10; k++) v[k] = t_cap[4*k+1];
        chk("t1_bits", v, 32'h2AA);
        chk("t1_busy_cycles", 32'(ones(b_cap, 0, 43)), 32'd40);
        chk("t1_busy_after", 32'(b_cap[40]), 32'd0);

        // 0x07 with even parity.
        start_tx(1, 8'h07);
        capture(1, 48, t_cap, b_cap);
        v = '0;
        for (int k = 0; k < 11; k++) v[k] = t_cap[4*k+1];
        chk("t2_bits", v, 32'h60E);
        chk("t2_busy_cycles", 32'(ones(b_cap, 0, 47)), 32'd44);

        // Back-to-back 0xA5, 0x3C with tx_valid held.
        @(posedge clk); #1;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hA5;
        @(posedge clk); #1;
        tx_data[0]  = 8'h3C;
        fork
            capture(0, 90, t_cap, b_cap);
            begin
                repeat (41) @(posedge clk);
                #1 tx_valid[0] = 1'b0;
            end
        join
        chk("t3_gap_idle", 32'(t_cap[40]), 32'd1);
        chk("t3_gap_notbusy", 32'(b_cap[40]), 32'd0);
        chk("t3_second_start", 32'(t_cap[41]), 32'd0);
        v = '0;
        for (int k = 0; k < 8; k++) v[k] = t_cap[41 + 4*(k+1) + 1];
        chk("t3_second_data", v, 32'h3C);

        // Reset 10 cycles into a frame of 0x00.
        start_tx(0, 8'h00);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < N; i++) mq[i].delete();
        #1;
        chk("t4_tx", 32'(tx[0]), 32'd1);
        chk("t4_ready", 32'(tx_ready[0]), 32'd1);
        chk("t4_busy", 32'(busy[0]), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        capture(0, 30, t_cap, b_cap);
        chk("t4_line_high", 32'(ones(t_cap, 0, 29)), 32'd30);
        chk("t4_no_busy", 32'(ones(b_cap, 0, 29)), 32'd0);

        // 0x0F, tx_data changed after transfer, tx_valid pulsed while busy.
        start_tx(0, 8'h0F);
        tx_data[0] = 8'hFF;
        fork
            capture(0, 60, t_cap, b_cap);
            begin
                repeat (20) @(posedge clk);
                #1;
                tx_valid[0] = 1'b1;
                tx_data[0]  = 8'hAA;
                @(posedge clk); #1;
                tx_valid[0] = 1'b0;
            end
        join
        v = '0;
        for (int k = 0; k < 8; k++) v[k] = t_cap[4*(k+1) + 1];
        chk("t5_data", v, 32'h0F);
        chk("t5_idle_after", 32'(ones(t_cap, 40, 59)), 32'd20);
        chk("t5_no_second", 32'(ones(b_cap, 40, 59)), 32'd0);

        // 0x80 with two stop bits at two clocks per bit.
        start_tx(2, 8'h80);
        capture(2, 26, t_cap, b_cap);
        chk("t6_busy_cycles", 32'(ones(b_cap, 0, 25)), 32'd22);
        chk("t6_last_busy", 32'(b_cap[21]), 32'd1);
        chk("t6_done", 32'(b_cap[22]), 32'd0);
        chk("t6_stop_high", 32'(ones(t_cap, 18, 21)), 32'd4);
        v = '0;
        for (int k = 0; k < 8; k++) v[k] = t_cap[2*(k+1)];
        chk("t6_data", v, 32'h80);
        chk("t6_start", 32'(t_cap[1]), 32'd0);

        // Random traffic on all three instances.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                tx_valid[i] = ($urandom_range(0, 3) == 0);
                tx_data[i]  = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        tx_valid = '0;
        repeat (100) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
